mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, `Addr_Width (32): address width.
- DATA_W, `Data_Width (32): data width.
- TAG_W, `Tag_Width (4): load tag width.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: clock. Reset rst, synchronous, active-high; clock clk.
- rst, in, 1: synchronous active-high reset.
- ld_req, in, 1: load request; held until ld_grant.
- ld_addr, in, ADDR_W: load address.
- ld_tag, in, TAG_W: load tag.
- ld_grant, out, 1: load accepted this cycle (combinational).
- ld_done, out, 1: load data valid pulse (registered).
- ld_data, out, DATA_W: returned word.
- ld_done_tag, out, TAG_W: tag of the returned load.
- st_req, in, 1: store request; held until st_grant.
- st_addr, in, ADDR_W: store address.
- st_data, in, DATA_W: store data.
- st_mask, in, 4: byte enables.
- st_grant, out, 1: store accepted this cycle (combinational).
- st_done, out, 1: store complete pulse (registered).
- flush, in, 1: squash the in-flight or pending load response.
- mem_free, in, 1: DataMemory ready.
- mem_read_valid, in, 1: DataMemory read data valid.
- mem_o_data, in, DATA_W: DataMemory read data.
- mem_rw_flag, out, 2: bit1 = read, bit0 = write (registered).
- mem_addr, out, ADDR_W: address to DataMemory.
- mem_i_data, out, DATA_W: write data to DataMemory.
- mem_mask, out, 4: byte mask to DataMemory.

Function
REQ-003 The FSM SHALL have three states:
- IDLE: on grant -> ISSUE.
- ISSUE: always -> WAIT.
- WAIT: on completion -> IDLE.

REQ-004 Grants SHALL assert only in IDLE with mem_free=1; at most one of ld_grant/st_grant SHALL be high per cycle.

REQ-005 When both requests are pending, the grant SHALL go to the requester not granted last (last_grant reg); a single pending request SHALL be granted directly.

REQ-006 On grant, the arbiter SHALL latch addr, data, mask, tag and op type. mem_addr, mem_i_data and mem_mask SHALL hold those values stable from ISSUE through WAIT.

REQ-007 mem_rw_flag SHALL be 2'b10 (load) or 2'b01 (store) only during the single ISSUE cycle, 2'b00 otherwise, and never 2'b11.

REQ-008 Reads SHALL drive mem_mask=4'b0000 and mem_i_data=0.

REQ-009 Load completion: in WAIT with mem_read_valid=1, the arbiter SHALL register ld_data=mem_o_data and ld_done_tag, pulse ld_done for 1 cycle, and return to IDLE.

REQ-010 Store completion: in WAIT with op=store and mem_free=1, the arbiter SHALL pulse st_done for 1 cycle and return to IDLE.

REQ-011 Latency (memory delay=1): grant in cycle N; ISSUE in N+1; mem_read_valid/mem_free in N+4; done pulse and IDLE in N+5; next grant possible in N+5.

REQ-012 flush=1 SHALL:
- drop a pending-but-ungranted load (ld_grant forced 0 that cycle);
- mark an in-flight load squashed: the memory access completes, ld_done is suppressed, the FSM returns to IDLE normally.

Stores SHALL be unaffected by flush.

REQ-013 A request arriving while not in IDLE SHALL wait; no request SHALL be lost or granted twice.

REQ-014 flush and completion in the same cycle SHALL suppress ld_done.

Reset
REQ-015 rst SHALL force:
- state=IDLE, last_grant=store (load wins the first tie);
- mem_rw_flag=0, mem_addr=0, mem_i_data=0, mem_mask=0;
- ld_done=0, st_done=0, ld_data=0, ld_done_tag=0, squash flag=0.

REQ-016 rst mid-operation SHALL abandon the transfer with no done pulse; DataMemory shares rst.

Structure
REQ-017 `Tag_Width, `Addr_Width and `Data_Width and the FSM state encodings SHALL reside in the shared defines header.

REQ-018 One sub-module, mem_rr_pick (2-way round-robin selector), SHALL be used; everything else SHALL be flat.

Verification
REQ-019 Load only: ld_req, addr=0x8, tag=3, mem[2]=0x12345678 -> ld_grant in N, mem_rw_flag=2'b10 in N+1 only, ld_done in N+5 with data=0x12345678 and tag=3.

REQ-020 Store: addr=0xC, data=0xAABBCCDD, mask=4'b0011 -> st_done in N+5; a subsequent load of 0xC returns low half 0xCCDD with the upper bytes preserved.

REQ-021 Simultaneous ld_req and st_req after reset -> load granted first, store granted in the IDLE cycle after ld_done; repeated contention alternates.

REQ-022 flush in N+2 of a load -> no ld_done, IDLE in N+5, a pending store is granted in N+5.

REQ-023 rst asserted in WAIT -> all outputs 0 next cycle, no done pulse; a new load afterwards completes normally.

REQ-024 Assertions SHALL check: no mem_rw_flag=2'b11; mem_addr stable through ISSUE/WAIT; grants one-hot-or-zero.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM state encoding and memory command
// codes used by the load/store arbiter and its bench.
package mem_arbiter_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_e;

  // mem_rw_flag encodings: bit1 = read, bit0 = write
  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_WRITE = 2'b01;

endpackage

// File: rtl/mem_rr_pick.sv
// mem_rr_pick: 2-way round-robin selector.
//   req_a, req_b   : pending requests
//   last_b         : 1 when requester b won the previous grant
//   pick_a, pick_b : one-hot-or-zero selection
module mem_rr_pick (
  input  logic req_a,
  input  logic req_b,
  input  logic last_b,
  output logic pick_a,
  output logic pick_b
);

  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (req_a && req_b) begin
      // tie: the side that did not win last time goes first
      pick_a = last_b;
      pick_b = !last_b;
    end else begin
      pick_a = req_a;
      pick_b = req_b;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one load port and one store port onto a single
// DataMemory interface, one transfer at a time.
//   clk, rst                 : clock, synchronous active-high reset
//   ld_req/addr/tag          : load request (held until ld_grant)
//   ld_grant                 : load accepted this cycle (combinational)
//   ld_done/data/done_tag    : registered load response pulse
//   st_req/addr/data/mask    : store request (held until st_grant)
//   st_grant, st_done        : store accepted / store complete pulse
//   flush                    : squash pending or in-flight load response
//   mem_free, mem_read_valid, mem_o_data : DataMemory status and read data
//   mem_rw_flag, mem_addr, mem_i_data, mem_mask : DataMemory command
//
// state   | meaning
// IDLE    | ready to grant when mem_free
// ISSUE   | command on mem_rw_flag for one cycle
// WAIT    | waiting for read valid (load) or mem_free (store)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int TAG_W  = TAG_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [TAG_W-1:0]  ld_tag,
  output logic              ld_grant,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_data,
  output logic [TAG_W-1:0]  ld_done_tag,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [3:0]        st_mask,
  output logic              st_grant,
  output logic              st_done,
  input  logic              flush,
  input  logic              mem_free,
  input  logic              mem_read_valid,
  input  logic [DATA_W-1:0] mem_o_data,
  output logic [1:0]        mem_rw_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_i_data,
  output logic [3:0]        mem_mask
);

  arb_state_e       state, state_nxt;
  op_e              op, last_grant;
  logic [TAG_W-1:0] tag_q;
  logic             squash;
  logic             can_grant, ld_cand, pick_ld, pick_st;
  logic             ld_cmpl, st_cmpl;

  assign can_grant = (state == S_IDLE) && mem_free && !rst;
  // a flushed load is not a candidate in that cycle
  assign ld_cand   = ld_req && !flush;

  mem_rr_pick u_pick (
    .req_a  (ld_cand),
    .req_b  (st_req),
    .last_b (last_grant == OP_STORE),
    .pick_a (pick_ld),
    .pick_b (pick_st)
  );

  assign ld_grant = can_grant && pick_ld;
  assign st_grant = can_grant && pick_st;
  assign ld_cmpl  = (state == S_WAIT) && (op == OP_LOAD)  && mem_read_valid;
  assign st_cmpl  = (state == S_WAIT) && (op == OP_STORE) && mem_free;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ld_grant || st_grant) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (ld_cmpl || st_cmpl) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      last_grant  <= OP_STORE;
      op          <= OP_LOAD;
      tag_q       <= '0;
      squash      <= 1'b0;
      mem_rw_flag <= RW_NONE;
      mem_addr    <= '0;
      mem_i_data  <= '0;
      mem_mask    <= '0;
      ld_done     <= 1'b0;
      st_done     <= 1'b0;
      ld_data     <= '0;
      ld_done_tag <= '0;
    end else begin
      state       <= state_nxt;
      ld_done     <= 1'b0;
      st_done     <= 1'b0;
      mem_rw_flag <= RW_NONE;
      if (ld_grant) begin
        op          <= OP_LOAD;
        last_grant  <= OP_LOAD;
        tag_q       <= ld_tag;
        mem_addr    <= ld_addr;
        mem_i_data  <= '0;
        mem_mask    <= 4'b0000;
        mem_rw_flag <= RW_READ;
        squash      <= 1'b0;
      end else if (st_grant) begin
        op          <= OP_STORE;
        last_grant  <= OP_STORE;
        mem_addr    <= st_addr;
        mem_i_data  <= st_data;
        mem_mask    <= st_mask;
        mem_rw_flag <= RW_WRITE;
        squash      <= 1'b0;
      end else if (flush && (op == OP_LOAD) && (state != S_IDLE)) begin
        squash <= 1'b1;
      end
      // flush arriving together with the read data also kills the response
      if (ld_cmpl) begin
        squash <= 1'b0;
        if (!(squash || flush)) begin
          ld_done     <= 1'b1;
          ld_data     <= mem_o_data;
          ld_done_tag <= tag_q;
        end
      end
      if (st_cmpl) st_done <= 1'b1;
    end
  end

endmodule
